// File: rtl/jm65_int_pkg.sv
// rtl/jm65_int_pkg.sv - shared types and vector constants for the interrupt controller
// Purpose: request kinds, controller states and fixed vector addresses used by
//          interrupt_controller and by anything that decodes its request.
// Ports:   none (package).
package jm65_int_pkg;

   typedef enum logic [1:0] {
      INT_NONE  = 2'd0,
      INT_RESET = 2'd1,
      INT_NMI   = 2'd2,
      INT_IRQ   = 2'd3
   } int_kind_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } int_state_t;

   localparam logic [15:0] VEC_NMI = 16'hFFFA;
   localparam logic [15:0] VEC_RES = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ = 16'hFFFE;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - multi-stage flop synchroniser for asynchronous input pins
// Purpose: brings WIDTH asynchronous bits into the clk domain through STAGES flops.
//          The chain resets to RESET_VAL so active-low pins start out inactive.
// Ports:   clk   in  1      sampling clock
//          resb  in  1      asynchronous active-low reset
//          d     in  WIDTH  asynchronous input bits
//          q     out WIDTH  synchronised bits, STAGES clocks behind d
module int_sync #(
   parameter int   WIDTH     = 1,
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             resb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   // The chain free-runs regardless of core ready so that a pin change is
   // never stretched or lost while the core is stalled.
   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= {WIDTH{RESET_VAL}};
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritised RESET/NMI/IRQ request generator for the core
// Purpose: synchronises NMI and N_IRQ IRQ lines, latches NMI falling edges, masks and
//          prioritises IRQs, and at instruction boundaries locks one request
//          (kind, vector, channel) that is held until the decoder acknowledges it.
// Ports:   clk          in   1      core clock
//          resb         in   1      asynchronous active-low reset
//          nmib         in   1      NMI pin, active-low, asynchronous
//          irqb         in   N_IRQ  IRQ pins, active-low, level, asynchronous
//          irq_en       in   N_IRQ  per-channel enable
//          i_flag       in   1      PSR I bit, masks all IRQs
//          rdy          in   1      core ready; controller state frozen while low
//          sync         in   1      opcode fetch cycle (instruction boundary)
//          int_ack      in   1      vector fetch of the current request done
//          int_req      out  1      request pending to decoder
//          int_kind     out  2      kind of the locked request
//          int_vector   out  16     vector address to fetch
//          int_chan     out  4      IRQ channel serviced
//          nmi_pending  out  1      latched NMI not yet serviced
module interrupt_controller
   import jm65_int_pkg::*;
#(
   parameter int          N_IRQ        = 8,
   parameter int          SYNC_STAGES  = 2,
   parameter int          VECTORED     = 0,
   parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0
) (
   input  logic             clk,
   input  logic             resb,
   input  logic             nmib,
   input  logic [N_IRQ-1:0] irqb,
   input  logic [N_IRQ-1:0] irq_en,
   input  logic             i_flag,
   input  logic             rdy,
   input  logic             sync,
   input  logic             int_ack,
   output logic             int_req,
   output int_kind_t        int_kind,
   output logic [15:0]      int_vector,
   output logic [3:0]       int_chan,
   output logic             nmi_pending
);

   // Lowest-numbered active channel; scanning downwards lets the lowest index
   // overwrite any higher one.
   function automatic logic [3:0] first_active(input logic [N_IRQ-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [15:0] irq_vector(input logic [3:0] chan);
      logic [15:0] vec;
      if (VECTORED != 0) begin
         vec = IRQ_VEC_BASE + {11'b0, chan, 1'b0};
      end else begin
         vec = VEC_IRQ;
      end
      return vec;
   endfunction

   logic             nmib_s;
   logic [N_IRQ-1:0] irqb_s;

   int_sync #(
      .WIDTH     (1),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync_nmi (
      .clk  (clk),
      .resb (resb),
      .d    (nmib),
      .q    (nmib_s)
   );

   int_sync #(
      .WIDTH     (N_IRQ),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync_irq (
      .clk  (clk),
      .resb (resb),
      .d    (irqb),
      .q    (irqb_s)
   );

   int_state_t  state,      state_d;
   int_kind_t   kind_q,     kind_d;
   logic [15:0] vector_q,   vector_d;
   logic [3:0]  chan_q,     chan_d;
   logic        reset_pend, reset_pend_d;
   logic        nmi_pend,   nmi_pend_d;
   logic        nmib_prev,  nmib_prev_d;

   logic [N_IRQ-1:0] irq_active;
   logic             nmi_fall;
   logic [3:0]       irq_chan;

   assign irq_active = ~irqb_s & irq_en & {N_IRQ{~i_flag}};
   assign irq_chan   = first_active(irq_active);

   // nmib_prev only advances with rdy, so an edge arriving while the core is
   // stalled is still seen once rdy returns. A held-low pin yields one edge.
   assign nmi_fall = nmib_prev & ~nmib_s;

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         state      <= IDLE;
         kind_q     <= INT_NONE;
         vector_q   <= VEC_RES;
         chan_q     <= '0;
         reset_pend <= 1'b1;
         nmi_pend   <= 1'b0;
         nmib_prev  <= 1'b1;
      end else begin
         state      <= state_d;
         kind_q     <= kind_d;
         vector_q   <= vector_d;
         chan_q     <= chan_d;
         reset_pend <= reset_pend_d;
         nmi_pend   <= nmi_pend_d;
         nmib_prev  <= nmib_prev_d;
      end
   end

   always_comb begin
      state_d      = state;
      kind_d       = kind_q;
      vector_d     = vector_q;
      chan_d       = chan_q;
      reset_pend_d = reset_pend;
      nmi_pend_d   = nmi_pend;
      nmib_prev_d  = nmib_prev;

      if (rdy) begin
         nmib_prev_d = nmib_s;

         case (state)
            IDLE: begin
               // Acks seen here are stale and ignored.
               if (sync) begin
                  if (reset_pend) begin
                     state_d  = REQ;
                     kind_d   = INT_RESET;
                     vector_d = VEC_RES;
                     chan_d   = '0;
                  end else if (nmi_pend) begin
                     state_d  = REQ;
                     kind_d   = INT_NMI;
                     vector_d = VEC_NMI;
                     chan_d   = '0;
                  end else if (|irq_active) begin
                     state_d  = REQ;
                     kind_d   = INT_IRQ;
                     vector_d = irq_vector(irq_chan);
                     chan_d   = irq_chan;
                  end
               end
            end
            REQ: begin
               // The locked request is never re-prioritised; newer sources
               // just pend until the next boundary.
               if (int_ack) begin
                  if (kind_q == INT_RESET) begin
                     reset_pend_d = 1'b0;
                  end
                  if (kind_q == INT_NMI) begin
                     nmi_pend_d = 1'b0;
                  end
                  kind_d  = INT_NONE;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // A fresh edge overrides a same-cycle clear so it is not lost.
         if (nmi_fall) begin
            nmi_pend_d = 1'b1;
         end
      end
   end

   assign int_req     = (state == REQ);
   assign int_kind    = kind_q;
   assign int_vector  = vector_q;
   assign int_chan    = chan_q;
   assign nmi_pending = nmi_pend;

endmodule
